// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result handshake bundle for the bit-serial adder
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first unsigned adder with carry flop and done pulse
module half_add (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic             cout_r;
  logic [CW-1:0]    cnt;

  logic             ha0_s;
  logic             ha0_c;
  logic             bit_s;
  logic             ha1_c;
  logic             carry_nxt;
  logic             last_bit;

  // Full adder: two half adders, carries OR'd together.
  half_add u_ha0 (.x(sh_a[0]), .y(sh_b[0]), .s(ha0_s), .c(ha0_c));
  half_add u_ha1 (.x(ha0_s),   .y(carry),   .s(bit_s), .c(ha1_c));

  assign carry_nxt = ha0_c | ha1_c;
  assign last_bit  = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == FIN);
    bus.sum  = sum_r;
    bus.cout = cout_r;
  end

  // cout is captured on the last RUN edge so it is already valid during FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a   <= '0;
      sh_b   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sh_a   <= bus.a;
            sh_b   <= bus.b;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            cnt    <= '0;
          end
        end
        RUN: begin
          sum_r <= {bit_s, sum_r[WIDTH-1:1]};
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          carry <= carry_nxt;
          cnt   <= cnt + CW'(1);
          if (last_bit) cout_r <= carry_nxt;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder at WIDTH 8, 2 and 32
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8))  i8 ();
  serial_adder_if #(.WIDTH(2))  i2 ();
  serial_adder_if #(.WIDTH(32)) i32 ();

  serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(i8.slave));
  serial_adder #(.WIDTH(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(i2.slave));
  serial_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(i32.slave));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Model of the 8-bit instance: cycles since acceptance, and the expected result.
  int         m_cyc   = -1;
  bit         m_valid = 1'b1;
  logic [8:0] m_exp   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc   = -1;
      m_valid = 1'b1;
      m_exp   = '0;
    end else if (m_cyc == -1) begin
      if (i8.start) begin
        m_cyc   = 1;
        m_valid = 1'b0;
        m_exp   = {1'b0, i8.a} + {1'b0, i8.b};
      end
    end else if (m_cyc == 9) begin
      m_cyc   = -1;
      m_valid = 1'b1;
    end else begin
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    check("model_busy", {63'd0, i8.busy}, {63'd0, (m_cyc >= 1 && m_cyc <= 8)});
    check("model_done", {63'd0, i8.done}, {63'd0, (m_cyc == 9)});
    if (m_cyc == 9 || (m_cyc == -1 && m_valid))
      check("model_result", {55'd0, i8.cout, i8.sum}, {55'd0, m_exp});
  end

  task automatic wait_done8(output int k);
    k = 1;
    while (!i8.done && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic op8(input logic [7:0] ai, input logic [7:0] bi,
                     input logic [7:0] es, input logic ec, input string nm);
    int k;
    @(negedge clk);
    i8.start = 1'b1; i8.a = ai; i8.b = bi;
    @(negedge clk);
    i8.start = 1'b0; i8.a = 8'($urandom); i8.b = 8'($urandom);
    wait_done8(k);
    check({nm, "_latency"}, 64'(k), 64'd9);
    check({nm, "_sum"}, {56'd0, i8.sum}, {56'd0, es});
    check({nm, "_cout"}, {63'd0, i8.cout}, {63'd0, ec});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int dcount;
    logic [7:0]  ea8, eb8;
    logic [1:0]  ea2, eb2;
    logic [31:0] ea32, eb32;

    i8.start = 1'b1;  i8.a = 8'h12; i8.b = 8'h34;
    i2.start = 1'b0;  i2.a = '0;    i2.b = '0;
    i32.start = 1'b0; i32.a = '0;   i32.b = '0;

    // Reset held with start asserted.
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, i8.busy}, 64'd0);
    check("rst_done", {63'd0, i8.done}, 64'd0);
    check("rst_sum",  {56'd0, i8.sum},  64'd0);
    check("rst_cout", {63'd0, i8.cout}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_accept", {63'd0, i8.busy}, 64'd1);
    i8.start = 1'b0;
    wait_done8(k);
    check("rst_release_sum", {56'd0, i8.sum}, 64'h46);

    // Basic add and hold.
    op8(8'h15, 8'h27, 8'h3C, 1'b0, "basic");
    repeat (20) @(negedge clk);
    check("basic_hold", {56'd0, i8.sum}, 64'h3C);

    // Carry chain and overflow.
    op8(8'hFF, 8'h01, 8'h00, 1'b1, "ff_01");
    op8(8'hFF, 8'hFF, 8'hFE, 1'b1, "ff_ff");
    op8(8'h80, 8'h80, 8'h00, 1'b1, "80_80");
    op8(8'h00, 8'h00, 8'h00, 1'b0, "zero");

    // Start while busy is ignored.
    @(negedge clk);
    i8.start = 1'b1; i8.a = 8'h0F; i8.b = 8'h01;
    @(negedge clk);
    i8.start = 1'b0;
    repeat (2) @(negedge clk);
    i8.start = 1'b1; i8.a = 8'hAA; i8.b = 8'h55;
    @(negedge clk);
    i8.start = 1'b0;
    wait_done8(k);
    check("busy_ign_sum",  {56'd0, i8.sum},  64'h10);
    check("busy_ign_cout", {63'd0, i8.cout}, 64'd0);
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (i8.done) dcount++;
    end
    check("busy_ign_no_second_done", 64'(dcount), 64'd0);

    // Asynchronous reset in RUN cycle 4.
    i8.start = 1'b1; i8.a = 8'h77; i8.b = 8'h99;
    @(negedge clk);
    i8.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {63'd0, i8.busy}, 64'd0);
    check("midrst_done", {63'd0, i8.done}, 64'd0);
    check("midrst_sum",  {56'd0, i8.sum},  64'd0);
    check("midrst_cout", {63'd0, i8.cout}, 64'd0);
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (i8.done) dcount++;
    end
    check("midrst_no_done", 64'(dcount), 64'd0);
    rst_n = 1'b1;
    op8(8'h3A, 8'hC7, 8'h01, 1'b1, "after_rst");

    // Back-to-back with start held, WIDTH=8.
    @(negedge clk);
    i8.start = 1'b1;
    for (int i = 0; i < 500; i++) begin
      ea8 = 8'($urandom); eb8 = 8'($urandom);
      i8.a = ea8; i8.b = eb8;
      k = 0;
      do begin @(negedge clk); k++; end while (!i8.done && k < 100);
      check("w8_interval", 64'(k), (i == 0) ? 64'd9 : 64'd10);
      check("w8_result", {55'd0, i8.cout, i8.sum}, 64'({1'b0, ea8} + {1'b0, eb8}));
    end
    i8.start = 1'b0;

    // WIDTH=2.
    @(negedge clk);
    i2.start = 1'b1;
    for (int i = 0; i < 500; i++) begin
      ea2 = 2'($urandom); eb2 = 2'($urandom);
      i2.a = ea2; i2.b = eb2;
      k = 0;
      do begin @(negedge clk); k++; end while (!i2.done && k < 100);
      check("w2_interval", 64'(k), (i == 0) ? 64'd3 : 64'd4);
      check("w2_result", {61'd0, i2.cout, i2.sum}, 64'({1'b0, ea2} + {1'b0, eb2}));
    end
    i2.start = 1'b0;

    // WIDTH=32.
    @(negedge clk);
    i32.start = 1'b1;
    for (int i = 0; i < 500; i++) begin
      ea32 = $urandom; eb32 = $urandom;
      if (i == 0) begin ea32 = 32'hFFFF_FFFF; eb32 = 32'h0000_0001; end
      i32.a = ea32; i32.b = eb32;
      k = 0;
      do begin @(negedge clk); k++; end while (!i32.done && k < 100);
      check("w32_interval", 64'(k), (i == 0) ? 64'd33 : 64'd34);
      check("w32_result", {31'd0, i32.cout, i32.sum}, 64'({1'b0, ea32} + {1'b0, eb32}));
    end
    i32.start = 1'b0;

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
